// File: rtl/key_debouncer.sv
// key_debouncer
//
// Conditions raw pushbutton pins for the music player's user interface.
// Each key is synchronised, debounced, and turned into a clean level plus
// single-cycle press, release and auto-repeat event pulses.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   key_in       raw pin levels, asynchronous to clk
//   key_state    debounced level per key, 1 = pressed
//   key_press    1-cycle pulse when a press is accepted
//   key_release  1-cycle pulse when a release is accepted
//   key_repeat   1-cycle pulse per auto-repeat tick while a key is held
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // When REPEAT_CYCLES exceeds HOLD_CYCLES the reload value
    // HOLD_CYCLES-REPEAT_CYCLES would be negative, so the hold counter is
    // offset by this bias to keep it unsigned without ever wrapping.
    localparam int HOLD_BIAS  = (REPEAT_CYCLES > HOLD_CYCLES) ? (REPEAT_CYCLES - HOLD_CYCLES) : 0;
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES + HOLD_BIAS) ?
                                DEBOUNCE_CYCLES : (HOLD_CYCLES + HOLD_BIAS);
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] DCNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HCNT_START  = CW'(HOLD_BIAS);
    localparam logic [CW-1:0] HCNT_FIRE   = CW'(HOLD_CYCLES + HOLD_BIAS);
    localparam logic [CW-1:0] HCNT_RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES + HOLD_BIAS);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] pressed;

    // Two-flop synchroniser; both stages come out of reset at the released
    // pin level so no phantom press is seen after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= {N_KEYS{ACTIVE_LOW}};
            sync2 <= {N_KEYS{ACTIVE_LOW}};
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ {N_KEYS{ACTIVE_LOW}};

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] dcnt;
        logic [CW-1:0] dcnt_nxt;
        logic [CW-1:0] hcnt;
        logic [CW-1:0] hcnt_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;
        logic          repeat_q;
        logic          repeat_nxt;
        logic          p;

        assign p = pressed[k];

        // State, counters and all outputs are registered together so every
        // output changes on the same edge as the transition that caused it.
        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= RELEASED;
                dcnt      <= '0;
                hcnt      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                dcnt      <= dcnt_nxt;
                hcnt      <= hcnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                repeat_q  <= repeat_nxt;
            end
        end

        // Debounce / hold FSM. Any opposite-level sample during a WAIT state
        // aborts the change, so a new attempt always needs a full run.
        always_comb begin
            state_nxt   = state;
            dcnt_nxt    = dcnt;
            hcnt_nxt    = hcnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            repeat_nxt  = 1'b0;
            case (state)
                RELEASED: begin
                    if (p) begin
                        state_nxt = PRESS_WAIT;
                        dcnt_nxt  = ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state_nxt = RELEASED;
                    end else if (dcnt == DCNT_LAST) begin
                        state_nxt = HELD;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        hcnt_nxt  = HCNT_START;
                    end else begin
                        dcnt_nxt = dcnt + ONE;
                    end
                end
                HELD: begin
                    // With repeat disabled the counter saturates at the fire
                    // value; with it enabled the reload keeps it below.
                    if (!p) begin
                        state_nxt = RELEASE_WAIT;
                        dcnt_nxt  = ONE;
                    end else if (hcnt != HCNT_FIRE) begin
                        hcnt_nxt = hcnt + ONE;
                        if (REPEAT_EN && (hcnt_nxt == HCNT_FIRE)) begin
                            repeat_nxt = 1'b1;
                            hcnt_nxt   = HCNT_RELOAD;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state_nxt = HELD;
                        hcnt_nxt  = HCNT_START;
                    end else if (dcnt == DCNT_LAST) begin
                        state_nxt   = RELEASED;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        dcnt_nxt = dcnt + ONE;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                end
            endcase
        end

        assign key_state[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_repeat[k]  = repeat_q;
    end

endmodule
